blit_sched: RTL and testbench

Command scheduler for the blitter rectangle walker. It accepts rectangle commands from two requesters (port 0: CPU command register, port 1: DMA descriptor engine) and arbitrates between them round-robin. It loads the winning command into the walker, holds the walker's start for exactly the walk, then drains the downstream pipeline and reports completion. It also generates the pixel valid/last qualifiers that travel alongside the walker's registered coordinate outputs.

---
 rtl/blit_sched.sv | 132 +++++++++++++
 tb/tb_blit_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_sched.sv
// Round-robin command scheduler for the blitter rectangle walker: grants one of two
// requesters, runs the walker, drains the pipeline and pulses completion.
module blit_sched #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [96:0] req0_cmd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [96:0] req1_cmd,
  output logic        dr_start,
  output logic        dr_reversed,
  output logic [15:0] dr_width,
  output logic [15:0] dr_height,
  output logic [15:0] dr_x1,
  output logic [15:0] dr_y1,
  output logic [15:0] dr_x2,
  output logic [15:0] dr_y2,
  input  logic        dr_done,
  output logic        p2_valid,
  output logic        p2_last,
  output logic        busy,
  output logic        cmd_done,
  output logic        cmd_done_id
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [96:0] cmd_q, cmd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        p2v_q, p2v_d;
  logic        p2l_q, p2l_d;
  logic        grant0, grant1;
  logic [96:0] sel_cmd;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    p2v_d   = p2v_q;
    p2l_d   = p2l_q;
    // On contention the port that did not win last time gets the grant
    grant0     = req0_valid && (!req1_valid || last_q);
    grant1     = req1_valid && (!req0_valid || !last_q);
    req0_ready = (state_q == IDLE) && grant0;
    req1_ready = (state_q == IDLE) && grant1;
    sel_cmd    = req1_ready ? req1_cmd : req0_cmd;

    // Pixel qualifiers advance in lockstep with the walker's p2 registers
    if (!stall) begin
      p2v_d = (state_q == RUN);
      p2l_d = (state_q == RUN) && dr_done;
    end

    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          id_d    = req1_ready;
          last_d  = req1_ready;
          cmd_d   = sel_cmd;
          state_d = (sel_cmd[95:80] == 16'd0 || sel_cmd[79:64] == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (dr_done && !stall) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
            cnt_d   = 4'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          if (cnt_q <= 4'd1) begin
            state_d = DONE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      cmd_q   <= '0;
      cnt_q   <= '0;
      p2v_q   <= 1'b0;
      p2l_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      p2v_q   <= p2v_d;
      p2l_q   <= p2l_d;
    end
  end

  assign dr_start    = (state_q == RUN);
  assign busy        = (state_q != IDLE);
  assign cmd_done    = (state_q == DONE);
  assign cmd_done_id = id_q;
  assign p2_valid    = p2v_q;
  assign p2_last     = p2l_q;
  assign dr_reversed = cmd_q[96];
  assign dr_width    = cmd_q[95:80];
  assign dr_height   = cmd_q[79:64];
  assign dr_x1       = cmd_q[63:48];
  assign dr_y1       = cmd_q[47:32];
  assign dr_x2       = cmd_q[31:16];
  assign dr_y2       = cmd_q[15:0];

endmodule

// File: tb/tb_blit_sched.sv
// Scoreboard bench for blit_sched: a walker model supplies dr_done, the driver queues
// expected completions and a negedge monitor checks each cmd_done against the queue.
module tb_blit_sched;
  localparam int DRAIN = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [96:0] req0_cmd = '0, req1_cmd = '0;
  logic        dr_start, dr_reversed, dr_done;
  logic [15:0] dr_width, dr_height, dr_x1, dr_y1, dr_x2, dr_y2;
  logic        p2_valid, p2_last, busy, cmd_done, cmd_done_id;

  always #5 clock = ~clock;

  blit_sched #(.DRAIN_CYCLES(DRAIN)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .dr_start(dr_start), .dr_reversed(dr_reversed),
    .dr_width(dr_width), .dr_height(dr_height),
    .dr_x1(dr_x1), .dr_y1(dr_y1), .dr_x2(dr_x2), .dr_y2(dr_y2),
    .dr_done(dr_done), .p2_valid(p2_valid), .p2_last(p2_last),
    .busy(busy), .cmd_done(cmd_done), .cmd_done_id(cmd_done_id)
  );

  // Walker model: one pixel per unstalled RUN cycle, dr_done on the final one
  logic [31:0] wcnt, total;
  assign total   = {16'd0, dr_width} * {16'd0, dr_height};
  assign dr_done = dr_start && (wcnt == total - 32'd1);
  always @(posedge clock or negedge reset) begin
    if (!reset)                 wcnt <= '0;
    else if (!dr_start)         wcnt <= '0;
    else if (!stall && !dr_done) wcnt <= wcnt + 32'd1;
  end

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [96:0] act, input logic [96:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        id;
    logic [96:0] cmd;
    int          lat;
    int          run;
    int          pix;
  } exp_t;
  exp_t q[$];

  function automatic logic [96:0] mk(input logic rev, input logic [15:0] w, h, x1, y1, x2, y2);
    return {rev, w, h, x1, y1, x2, y2};
  endfunction

  // Expected latency from the grant cycle to the cmd_done cycle
  function automatic void push_exp(input logic id, input logic [96:0] cmd, input int stall_cyc);
    exp_t e;
    int n;
    n     = int'(cmd[95:80]) * int'(cmd[79:64]);
    e.id  = id;
    e.cmd = cmd;
    e.pix = n;
    e.lat = (n == 0) ? 1 : n + DRAIN + 1 + stall_cyc;
    e.run = (n == 0) ? 0 : n + stall_cyc;
    q.push_back(e);
  endfunction

  // Monitor
  int   grant_cyc = 0, strobes = 0, lasts = 0, lastpos = 0, runc = 0;
  logic pst = 1'b0, pv = 1'b0, pl = 1'b0, pdone = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      strobes = 0; lasts = 0; lastpos = 0; runc = 0; pst = 1'b0; pdone = 1'b0;
    end else begin
      if (pdone) chk("busy_after_done", busy, 0);
      if (req0_ready || req1_ready) begin
        chk("ready_excl", req0_ready & req1_ready, 0);
        chk("ready_idle", busy, 0);
        grant_cyc = cyc; strobes = 0; lasts = 0; lastpos = 0; runc = 0;
      end
      if (dr_start) runc++;
      if (pst) chk("p2_hold", {p2_valid, p2_last}, {pv, pl});
      if (p2_valid && !stall) strobes++;
      if (p2_last && !stall) begin lasts++; lastpos = strobes; end
      pst = stall; pv = p2_valid; pl = p2_last;
      pdone = cmd_done;
      if (cmd_done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_id", cmd_done_id, e.id);
          chk("done_busy", busy, 1);
          chk("fields", {dr_reversed, dr_width, dr_height, dr_x1, dr_y1, dr_x2, dr_y2}, e.cmd);
          chk("latency", cyc - grant_cyc, e.lat);
          chk("run_cycles", runc, e.run);
          chk("strobes", strobes, e.pix);
          chk("last_count", lasts, (e.pix > 0) ? 1 : 0);
          chk("last_pos", lastpos, e.pix);
        end
      end
    end
  end

  task automatic issue(input logic port, input logic [96:0] cmd);
    if (port) begin req1_cmd = cmd; req1_valid = 1'b1; end
    else      begin req0_cmd = cmd; req0_valid = 1'b1; end
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (port ? req1_ready : req0_ready) begin
        @(posedge clock); #1;
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
        return;
      end
    end
    chk("grant_timeout", 0, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic issue_both(input logic [96:0] c0, input logic [96:0] c1);
    logic r0, r1;
    req0_cmd = c0; req1_cmd = c1; req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      r0 = req0_ready; r1 = req1_ready;
      @(posedge clock); #1;
      if (r0) req0_valid = 1'b0;
      if (r1) req1_valid = 1'b0;
      if (!req0_valid && !req1_valid) return;
    end
    chk("both_timeout", 0, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500; i++) begin
      if (q.size() == 0) begin
        repeat (2) @(posedge clock);
        #1;
        return;
      end
      @(posedge clock);
    end
    chk("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    logic [96:0] c;
    #12;
    chk("rst_ctrl", {busy, dr_start, cmd_done, cmd_done_id, p2_valid, p2_last, req0_ready, req1_ready}, 0);
    chk("rst_fields", {dr_reversed, dr_width, dr_height, dr_x1, dr_y1, dr_x2, dr_y2}, 0);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;

    // Contention from reset: port 0, port 1, then port 0, port 1 again
    push_exp(0, mk(0, 1, 1, 1, 0, 0, 0), 0);
    push_exp(1, mk(0, 1, 1, 2, 0, 0, 0), 0);
    issue_both(mk(0, 1, 1, 1, 0, 0, 0), mk(0, 1, 1, 2, 0, 0, 0));
    wait_drain();
    push_exp(0, mk(0, 1, 1, 3, 0, 0, 0), 0);
    push_exp(1, mk(0, 1, 1, 4, 0, 0, 0), 0);
    issue_both(mk(0, 1, 1, 3, 0, 0, 0), mk(0, 1, 1, 4, 0, 0, 0));
    wait_drain();

    // Basic 3x2 rectangle
    c = mk(0, 3, 2, 10, 20, 100, 200);
    push_exp(0, c, 0);
    issue(0, c);
    wait_drain();

    // 4x1 with a 3-cycle stall after the walker's 2nd pixel
    c = mk(0, 4, 1, 7, 8, 9, 10);
    push_exp(0, c, 3);
    issue(0, c);
    for (int i = 0; i < 50; i++) begin
      if (wcnt == 32'd2) break;
      @(posedge clock); #1;
    end
    chk("stall_run_active", dr_start, 1);
    stall = 1'b1;
    repeat (3) @(posedge clock);
    #1 stall = 1'b0;
    wait_drain();

    // Zero-size commands from port 1
    c = mk(0, 0, 5, 1, 2, 3, 4);
    push_exp(1, c, 0);
    issue(1, c);
    wait_drain();
    c = mk(0, 5, 0, 5, 6, 7, 8);
    push_exp(1, c, 0);
    issue(1, c);
    wait_drain();

    // Reversed 2x2
    c = mk(1, 2, 2, 50, 50, 0, 0);
    push_exp(0, c, 0);
    issue(0, c);
    wait_drain();

    // Reset in the middle of an 8x8 walk discards the command
    issue(0, mk(0, 8, 8, 1, 1, 1, 1));
    repeat (5) @(posedge clock);
    #1;
    chk("run_before_reset", dr_start, 1);
    reset = 1'b0;
    #1;
    chk("reset_mid_run", {dr_start, busy, p2_valid, cmd_done}, 0);
    @(posedge clock); #1;
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;

    c = mk(0, 1, 1, 11, 12, 13, 14);
    push_exp(0, c, 0);
    issue(0, c);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
